alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Parametrised control sequencer that drives the datapath for one register-register ALU instruction: fetch T0–T2, then execute T3–T5, with optional T6.
- Generalises the fixed hand-timed control sequence: it decodes Ra/Rb/Rc into one-hot register strobes, waits on memory with a handshake, supports HI/LO-writing ops (MUL/DIV) and flags illegal opcodes.
- Sits between the IR output and the datapath control inputs of the CPU.

Parameters:
- DATA_WIDTH, 32, width of ir_in.
- NUM_REGS, 16, number of general registers; width of the Rin/Rout one-hot buses. Power of two, ≤16.
- OPCODE_WIDTH, 5, opcode field width; ir_in[DATA_WIDTH-1 -: OPCODE_WIDTH].
- LEGAL_MASK, 32'h0000_FFFF, bit k=1 means opcode k is a legal ALU op.
- MUL_OPCODE, 5'd15, opcode that writes LO then HI.
- DIV_OPCODE, 5'd16, opcode that writes LO then HI.

Ports:
- Clock  in  1  single clock, rising edge.
- Clear  in  1  synchronous, active-high reset.
- start  in  1  begin one instruction when idle.
- mem_ready  in  1  memory read data valid.
- ir_in  in  DATA_WIDTH  IR register contents.
- PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin  out  1 each  datapath strobes.
- Rin  out  NUM_REGS  one-hot register load.
- Rout  out  NUM_REGS  one-hot register drive.
- alu_op  out  OPCODE_WIDTH  ALU operation select.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle pulse, coincident with done, on a rejected opcode or register field.

Behaviour:
- Reset and outputs
  - Clear is sampled at posedge and wins over everything. State goes to IDLE and IR-derived fields are ignored.
  - All outputs are 0 in the cycle after a Clear edge. A Clear mid-instruction aborts it with no done pulse.
  - Outputs are Moore-decoded from the registered state plus ir_in. Any strobe not listed for a state is 0.
- IR fields
  - ra = ir_in[DATA_WIDTH-OPCODE_WIDTH-1 -: 4], rb is the next 4 bits, rc the next 4 bits.
  - Example: 0x4A920000 gives op=9, ra=5, rb=2, rc=4.
- State sequence
  - IDLE: start=1 → T0; otherwise stay.
  - T0: PCout, MARin, IncPC, ZLowIn → T1.
  - T1: Zlowout, PCin, Read → T1W.
  - T1W: Read=1; MDRin=mem_ready. mem_ready=1 → T2, else stay (no timeout).
  - T2: MDRout, IRin → T3. IR is valid from T3 on.
  - T3: if op is illegal (LEGAL_MASK[op]=0) or any of ra/rb/rc ≥ NUM_REGS → FIN with illegal=1 and all strobes 0. Otherwise Rout[rb]=1, Yin → T4.
  - T4: Rout[rc]=1, alu_op=op, ZLowIn. ZHighIn is also asserted if op is MUL_OPCODE or DIV_OPCODE → T5.
  - T5: Zlowout. For MUL/DIV, LOin → T6. Otherwise Rin[ra]=1 → FIN.
  - T6: ZHighout, HIin → FIN.
  - FIN: done=1 → IDLE. start is ignored in FIN; a new instruction needs start in IDLE.
- Invariants
  - alu_op=0 outside T4.
  - Rin and Rout are at most one-hot, never both nonzero in the same cycle.
  - Zlowout and ZHighout are never both high.
- Latency
  - Fixed path (FIN counted): minimum 8 cycles start→done for normal ops, 9 for MUL/DIV.
  - Each cycle mem_ready is low in T1W adds one.
- Other rules
  - start while busy is ignored.
  - ra=rb=rc is legal; strobe sequencing is unchanged.

Test Plan:
- OR-style op: Clear 2 cycles, start, mem_ready=1, ir_in=0x4A920000 → T3 Rout=0x0004 with Yin; T4 Rout=0x0010, alu_op=9, ZLowIn; T5 Rin=0x0020 with Zlowout; done 8 cycles after start; illegal=0.
- Memory wait: same instruction with mem_ready low for 3 cycles in T1W → Read high 4 cycles; MDRin high only on the last; done at cycle 11.
- MUL: ir_in=0x7A920000 (op=15) → T4 ZLowIn=ZHighIn=1; T5 Zlowout+LOin with Rin=0; T6 ZHighout+HIin; done at cycle 9.
- Illegal: ir_in=0xF8000000 (op=31, mask bit 0) → at T3 all strobes 0 and next cycle done=illegal=1; no Rin, LOin or HIin ever asserted.
- Reset mid-op: assert Clear during T4 → next cycle busy=0, all outputs 0, no done pulse; a following start runs normally from T0.
- start held high continuously → done every 9 cycles (8 plus one in IDLE); start asserted during busy has no effect on the sequence.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Control sequencer for one register-register ALU instruction: fetch (T0-T2), then execute (T3-T5, plus T6 for HI/LO ops).
// Strobes are Moore-decoded from the state register and ir_in. MDRin also follows mem_ready while in T1W.
module alu_op_sequencer #(
  parameter int unsigned                    DATA_WIDTH   = 32,
  parameter int unsigned                    NUM_REGS     = 16,
  parameter int unsigned                    OPCODE_WIDTH = 5,
  parameter logic [2**OPCODE_WIDTH-1:0]     LEGAL_MASK   = 32'h0000_FFFF,
  parameter logic [OPCODE_WIDTH-1:0]        MUL_OPCODE   = 5'd15,
  parameter logic [OPCODE_WIDTH-1:0]        DIV_OPCODE   = 5'd16
) (
  input  logic                    Clock,
  input  logic                    Clear,
  input  logic                    start,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   ir_in,
  output logic                    PCout,
  output logic                    MARin,
  output logic                    IncPC,
  output logic                    PCin,
  output logic                    Read,
  output logic                    MDRin,
  output logic                    MDRout,
  output logic                    IRin,
  output logic                    Yin,
  output logic                    ZLowIn,
  output logic                    ZHighIn,
  output logic                    Zlowout,
  output logic                    ZHighout,
  output logic                    LOin,
  output logic                    HIin,
  output logic [NUM_REGS-1:0]     Rin,
  output logic [NUM_REGS-1:0]     Rout,
  output logic [OPCODE_WIDTH-1:0] alu_op,
  output logic                    busy,
  output logic                    done,
  output logic                    illegal
);

  localparam int unsigned RF = 4;
  localparam int unsigned FTOP = DATA_WIDTH - OPCODE_WIDTH - 1;

  typedef enum logic [3:0] {IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, FIN} state_t;

  state_t state, next;

  logic [OPCODE_WIDTH-1:0] op;
  logic [RF-1:0]           ra, rb, rc;
  logic                    regs_ok, op_ok, hilo;
  logic                    unused_ir_bits;

  assign op = ir_in[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign ra = ir_in[FTOP -: RF];
  assign rb = ir_in[FTOP-RF -: RF];
  assign rc = ir_in[FTOP-2*RF -: RF];
  assign unused_ir_bits = ^ir_in[FTOP-3*RF:0];

  // Fields are 4 bits wide, so smaller register files must reject out-of-range indices.
  assign regs_ok = ({1'b0, ra} < 5'(NUM_REGS)) && ({1'b0, rb} < 5'(NUM_REGS)) &&
                   ({1'b0, rc} < 5'(NUM_REGS));
  assign op_ok   = LEGAL_MASK[op] && regs_ok;
  assign hilo    = (op == MUL_OPCODE) || (op == DIV_OPCODE);

  function automatic logic [NUM_REGS-1:0] onehot(input logic [RF-1:0] r);
    onehot = NUM_REGS'(1) << r;
  endfunction

  always_ff @(posedge Clock) begin
    if (Clear) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next     = state;
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    ZLowIn   = 1'b0;
    ZHighIn  = 1'b0;
    Zlowout  = 1'b0;
    ZHighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    alu_op   = '0;
    busy     = (state != IDLE);
    done     = 1'b0;
    illegal  = 1'b0;
    case (state)
      IDLE: if (start) next = T0;
      T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        ZLowIn = 1'b1;
        next   = T1;
      end
      T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        next    = T1W;
      end
      T1W: begin
        Read  = 1'b1;
        MDRin = mem_ready;
        if (mem_ready) next = T2;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        next   = T3;
      end
      // A rejected instruction skips execution entirely; FIN reports it.
      T3: begin
        if (op_ok) begin
          Rout = onehot(rb);
          Yin  = 1'b1;
          next = T4;
        end else begin
          next = FIN;
        end
      end
      T4: begin
        Rout    = onehot(rc);
        alu_op  = op;
        ZLowIn  = 1'b1;
        ZHighIn = hilo;
        next    = T5;
      end
      T5: begin
        Zlowout = 1'b1;
        if (hilo) begin
          LOin = 1'b1;
          next = T6;
        end else begin
          Rin  = onehot(ra);
          next = FIN;
        end
      end
      T6: begin
        ZHighout = 1'b1;
        HIin     = 1'b1;
        next     = FIN;
      end
      FIN: begin
        done    = 1'b1;
        illegal = !op_ok;
        next    = IDLE;
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: per-cycle expected outputs are queued at start and popped each cycle.
module tb_alu_op_sequencer;

  localparam logic [14:0] S_PCOUT    = 15'h4000;
  localparam logic [14:0] S_MARIN    = 15'h2000;
  localparam logic [14:0] S_INCPC    = 15'h1000;
  localparam logic [14:0] S_PCIN     = 15'h0800;
  localparam logic [14:0] S_READ     = 15'h0400;
  localparam logic [14:0] S_MDRIN    = 15'h0200;
  localparam logic [14:0] S_MDROUT   = 15'h0100;
  localparam logic [14:0] S_IRIN     = 15'h0080;
  localparam logic [14:0] S_YIN      = 15'h0040;
  localparam logic [14:0] S_ZLOWIN   = 15'h0020;
  localparam logic [14:0] S_ZHIGHIN  = 15'h0010;
  localparam logic [14:0] S_ZLOWOUT  = 15'h0008;
  localparam logic [14:0] S_ZHIGHOUT = 15'h0004;
  localparam logic [14:0] S_LOIN     = 15'h0002;
  localparam logic [14:0] S_HIIN     = 15'h0001;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic        start = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] ir_in = '0;
  logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin;
  logic [15:0] Rin, Rout;
  logic [4:0]  alu_op;
  logic        busy, done, illegal;
  logic [54:0] act;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  alu_op_sequencer #(
    .DATA_WIDTH(32), .NUM_REGS(16), .OPCODE_WIDTH(5),
    .LEGAL_MASK(32'h0000_FFFF), .MUL_OPCODE(5'd15), .DIV_OPCODE(5'd16)
  ) dut (
    .Clock(Clock), .Clear(Clear), .start(start), .mem_ready(mem_ready), .ir_in(ir_in),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn),
    .ZHighIn(ZHighIn), .Zlowout(Zlowout), .ZHighout(ZHighout), .LOin(LOin), .HIin(HIin),
    .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal)
  );

  assign act = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, ZLowIn, ZHighIn,
                Zlowout, ZHighout, LOin, HIin, Rin, Rout, alu_op, busy, done, illegal};

  typedef struct {
    logic [31:0] ir;
    int unsigned waits;
    bit          hilo;
    bit          ill;
    logic [15:0] r3;
    logic [15:0] r4;
    logic [15:0] r5;
    logic [4:0]  op;
  } vec_t;

  typedef struct {
    logic        mr;
    logic [54:0] exp;
  } cyc_t;

  vec_t vecs[7];
  cyc_t exp_q[$];

  function automatic logic [54:0] pack(input logic [14:0] s, input logic [15:0] rin,
                                       input logic [15:0] rout, input logic [4:0] op,
                                       input logic b, input logic d, input logic il);
    return {s, rin, rout, op, b, d, il};
  endfunction

  task automatic check(input string name, input logic [54:0] a, input logic [54:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, a, e);
    end
  endtask

  task automatic push(input logic mr, input logic [54:0] e);
    cyc_t c;
    c.mr  = mr;
    c.exp = e;
    exp_q.push_back(c);
  endtask

  // Expected per-cycle trace from T0 through the IDLE cycle after FIN.
  task automatic build(input vec_t v);
    push(1'b0, pack(S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN, '0, '0, '0, 1'b1, 1'b0, 1'b0));
    push(1'b0, pack(S_ZLOWOUT | S_PCIN | S_READ, '0, '0, '0, 1'b1, 1'b0, 1'b0));
    for (int unsigned w = 0; w < v.waits; w++)
      push(1'b0, pack(S_READ, '0, '0, '0, 1'b1, 1'b0, 1'b0));
    push(1'b1, pack(S_READ | S_MDRIN, '0, '0, '0, 1'b1, 1'b0, 1'b0));
    push(1'b0, pack(S_MDROUT | S_IRIN, '0, '0, '0, 1'b1, 1'b0, 1'b0));
    if (v.ill) begin
      push(1'b0, pack('0, '0, '0, '0, 1'b1, 1'b0, 1'b0));
      push(1'b0, pack('0, '0, '0, '0, 1'b1, 1'b1, 1'b1));
    end else begin
      push(1'b0, pack(S_YIN, '0, v.r3, '0, 1'b1, 1'b0, 1'b0));
      push(1'b0, pack(S_ZLOWIN | (v.hilo ? S_ZHIGHIN : 15'h0), '0, v.r4, v.op, 1'b1, 1'b0, 1'b0));
      if (v.hilo) begin
        push(1'b0, pack(S_ZLOWOUT | S_LOIN, '0, '0, '0, 1'b1, 1'b0, 1'b0));
        push(1'b0, pack(S_ZHIGHOUT | S_HIIN, '0, '0, '0, 1'b1, 1'b0, 1'b0));
      end else begin
        push(1'b0, pack(S_ZLOWOUT, v.r5, '0, '0, 1'b1, 1'b0, 1'b0));
      end
      push(1'b0, pack('0, '0, '0, '0, 1'b1, 1'b1, 1'b0));
    end
    push(1'b0, '0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    exp_q.delete();
    build(v);
    @(posedge Clock); #1;
    ir_in = v.ir;
    start = 1'b1;
    k = 0;
    while (exp_q.size() > 0) begin
      cyc_t c;
      c = exp_q.pop_front();
      k++;
      @(posedge Clock); #1;
      start     = 1'b0;
      mem_ready = c.mr;
      @(negedge Clock);
      check($sformatf("vec%0d_cyc%0d", idx, k), act, c.exp);
    end
  endtask

  initial begin
    vecs[0] = '{32'h4A92_0000, 0, 1'b0, 1'b0, 16'h0004, 16'h0010, 16'h0020, 5'd9};
    vecs[1] = '{32'h4A92_0000, 3, 1'b0, 1'b0, 16'h0004, 16'h0010, 16'h0020, 5'd9};
    vecs[2] = '{32'h7A92_0000, 0, 1'b1, 1'b0, 16'h0004, 16'h0010, 16'h0000, 5'd15};
    vecs[3] = '{32'hF800_0000, 0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 5'd0};
    vecs[4] = '{32'h1BBB_8000, 2, 1'b0, 1'b0, 16'h0080, 16'h0080, 16'h0080, 5'd3};
    vecs[5] = '{32'h8000_0000, 0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 5'd0};
    vecs[6] = '{32'h0000_0000, 1, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0001, 5'd0};

    repeat (2) @(posedge Clock);
    #1 Clear = 1'b0;
    @(negedge Clock);
    check("reset_state", act, '0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Clear during T4 aborts without a done pulse.
    @(posedge Clock); #1;
    ir_in = vecs[0].ir;
    start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge Clock); #1;
      start     = 1'b0;
      mem_ready = 1'b1;
    end
    @(negedge Clock);
    check("abort_in_t4", act, pack(S_ZLOWIN, '0, 16'h0010, 5'd9, 1'b1, 1'b0, 1'b0));
    Clear = 1'b1;
    @(posedge Clock); #1;
    Clear = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      check($sformatf("abort_idle%0d", k), act, '0);
    end
    run_vec(vecs[0], 7);

    // start held high: done every 9 cycles, start while busy ignored.
    @(posedge Clock); #1;
    ir_in     = vecs[0].ir;
    mem_ready = 1'b1;
    start     = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(posedge Clock); #1;
      @(negedge Clock);
      check($sformatf("held_cyc%0d", k), {53'd0, busy, done},
            {53'd0, (k % 9) != 0, (k % 9) == 8});
    end
    @(posedge Clock); #1;
    start = 1'b0;
    @(negedge Clock);
    check("held_release_idle", act, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
